// File: rtl/mcu_control_if.sv
// Handshake and strobe bundle between the MCU control FSM and the core datapath/memory side.
// The master modport belongs to the control FSM; the slave modport to the datapath/memory side.
interface mcu_control_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic                MCU_Run_In;
  logic [6:0]          MCU_Opcode_InBUS;
  logic                MCU_Imem_Valid_In;
  logic                MCU_Lsu_Ready_In;
  logic                MCU_Lsu_Valid_In;
  logic [2:0]          MCU_State_OutBUS;
  logic                MCU_Imem_Req;
  logic                MCU_Ir_Load;
  logic                MCU_Pc_Write;
  logic                MCU_Load_Wb;
  logic                MCU_Retire;
  logic [RETIRE_W-1:0] MCU_Retire_Count_OutBUS;
  logic                MCU_Trap;

  modport master (
    input  MCU_Run_In, MCU_Opcode_InBUS, MCU_Imem_Valid_In, MCU_Lsu_Ready_In, MCU_Lsu_Valid_In,
    output MCU_State_OutBUS, MCU_Imem_Req, MCU_Ir_Load, MCU_Pc_Write, MCU_Load_Wb,
           MCU_Retire, MCU_Retire_Count_OutBUS, MCU_Trap
  );

  modport slave (
    output MCU_Run_In, MCU_Opcode_InBUS, MCU_Imem_Valid_In, MCU_Lsu_Ready_In, MCU_Lsu_Valid_In,
    input  MCU_State_OutBUS, MCU_Imem_Req, MCU_Ir_Load, MCU_Pc_Write, MCU_Load_Wb,
           MCU_Retire, MCU_Retire_Count_OutBUS, MCU_Trap
  );
endinterface

// File: rtl/mcu_control_fsm.sv
// Main control FSM: sequences fetch/decode/execute/load-store waits, issues core strobes,
// and traps into a sticky halt on illegal opcodes or handshake timeouts.
module mcu_control_fsm #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W    = 8,
  parameter int unsigned RETIRE_W     = 32
) (
  input  logic          MCU_CLOCK_50,
  input  logic          MCU_RESET_InLow,
  mcu_control_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_FETCH  = 3'b001;
  localparam logic [2:0] S_DECODE = 3'b010;
  localparam logic [2:0] S_EXEC   = 3'b011;
  localparam logic [2:0] S_WVALID = 3'b100;
  localparam logic [2:0] S_WREADY = 3'b101;
  localparam logic [2:0] S_TRAP   = 3'b111;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT = TIMEOUT_W'(WAIT_TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RETIRE_W-1:0]  retire_cnt_q;

  logic [6:0] opc;
  logic       opc_legal, opc_mem, opc_store;
  logic       in_wait, handshake, timed_out;
  logic       imem_req, ir_load, pc_write, load_wb, retire, trap;

  assign opc       = bus.MCU_Opcode_InBUS;
  assign opc_mem   = (opc[6] == 1'b0) && (opc[4:0] == 5'b00011);
  assign opc_store = opc[5];

  always_comb begin
    opc_legal = 1'b0;
    case (opc)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: opc_legal = 1'b1;
      default: opc_legal = 1'b0;
    endcase
  end

  // Which handshake the current wait state is waiting on
  always_comb begin
    in_wait   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      S_FETCH:  begin in_wait = 1'b1; handshake = bus.MCU_Imem_Valid_In; end
      S_WREADY: begin in_wait = 1'b1; handshake = bus.MCU_Lsu_Ready_In;  end
      S_WVALID: begin in_wait = 1'b1; handshake = bus.MCU_Lsu_Valid_In;  end
      default:  begin in_wait = 1'b0; handshake = 1'b0; end
    endcase
  end

  assign timed_out = in_wait && !handshake && (wait_cnt_q == TIMEOUT);

  always_ff @(posedge MCU_CLOCK_50 or negedge MCU_RESET_InLow) begin
    if (!MCU_RESET_InLow) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  // Handshake is checked before timeout so a late handshake still wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.MCU_Run_In) state_d = S_FETCH;
      S_FETCH:  begin
        if (handshake)      state_d = S_DECODE;
        else if (timed_out) state_d = S_TRAP;
      end
      S_DECODE: state_d = opc_legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = opc_mem ? S_WREADY : S_FETCH;
      S_WREADY: begin
        if (handshake)      state_d = opc_store ? S_FETCH : S_WVALID;
        else if (timed_out) state_d = S_TRAP;
      end
      S_WVALID: begin
        if (handshake)      state_d = S_FETCH;
        else if (timed_out) state_d = S_TRAP;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    load_wb  = 1'b0;
    retire   = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = handshake;
      end
      S_EXEC: begin
        pc_write = !opc_mem;
        retire   = !opc_mem;
      end
      S_WREADY: begin
        pc_write = handshake && opc_store;
        retire   = handshake && opc_store;
      end
      S_WVALID: begin
        load_wb  = handshake;
        pc_write = handshake;
        retire   = handshake;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  // Any state change clears the counter; self-loops only happen while the handshake is low
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (in_wait && !handshake && (wait_cnt_q != CNT_MAX))
      wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge MCU_CLOCK_50 or negedge MCU_RESET_InLow) begin
    if (!MCU_RESET_InLow) begin
      wait_cnt_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (retire) retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
    end
  end

  assign bus.MCU_State_OutBUS        = state_q;
  assign bus.MCU_Imem_Req            = imem_req;
  assign bus.MCU_Ir_Load             = ir_load;
  assign bus.MCU_Pc_Write            = pc_write;
  assign bus.MCU_Load_Wb             = load_wb;
  assign bus.MCU_Retire              = retire;
  assign bus.MCU_Retire_Count_OutBUS = retire_cnt_q;
  assign bus.MCU_Trap                = trap;

endmodule

// File: tb/tb_mcu_control_fsm.sv
// Scoreboard bench for mcu_control_fsm: an instruction-level model expands each instruction into
// its expected per-cycle observation; a negedge monitor pops and compares.
module tb_mcu_control_fsm;

  localparam int unsigned TO = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned RW = 4;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_FETCH  = 3'b001;
  localparam logic [2:0] S_DECODE = 3'b010;
  localparam logic [2:0] S_EXEC   = 3'b011;
  localparam logic [2:0] S_WVALID = 3'b100;
  localparam logic [2:0] S_WREADY = 3'b101;
  localparam logic [2:0] S_TRAP   = 3'b111;

  // Strobe vector order: {imem_req, ir_load, pc_write, load_wb, retire, trap}
  localparam logic [5:0] SB_NONE = 6'b000000;
  localparam logic [5:0] SB_REQ  = 6'b100000;
  localparam logic [5:0] SB_IRL  = 6'b010000;
  localparam logic [5:0] SB_PCW  = 6'b001000;
  localparam logic [5:0] SB_LWB  = 6'b000100;
  localparam logic [5:0] SB_RET  = 6'b000010;
  localparam logic [5:0] SB_TRP  = 6'b000001;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] LEGAL [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                       7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                       7'b0110011};

  typedef struct packed {
    logic [2:0]    st;
    logic [5:0]    sb;
    logic [RW-1:0] cnt;
  } obs_t;

  logic clk;
  logic rst_n;
  obs_t exp_q[$];
  logic [RW-1:0] model_cnt;
  bit   mon_en;
  int   checks;
  int   errors;

  mcu_control_if #(.RETIRE_W(RW)) bus ();

  mcu_control_fsm #(.WAIT_TIMEOUT(TO), .TIMEOUT_W(TW), .RETIRE_W(RW)) dut (
    .MCU_CLOCK_50    (clk),
    .MCU_RESET_InLow (rst_n),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.st  = bus.MCU_State_OutBUS;
      a.sb  = {bus.MCU_Imem_Req, bus.MCU_Ir_Load, bus.MCU_Pc_Write, bus.MCU_Load_Wb,
               bus.MCU_Retire, bus.MCU_Trap};
      a.cnt = bus.MCU_Retire_Count_OutBUS;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got st=%b strobes=%b cnt=%0d, expected st=%b strobes=%b cnt=%0d",
                 $time, a.st, a.sb, a.cnt, e.st, e.sb, e.cnt);
      end
    end else if (mon_en) begin
      checks++;
      errors++;
      $display("FAIL underflow t=%0t got no expectation, expected one per cycle", $time);
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    foreach (LEGAL[i]) if (LEGAL[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned pick_delay();
    int unsigned r;
    r = $urandom_range(9, 0);
    if (r < 6) return $urandom_range(2, 0);
    if (r < 9) return $urandom_range(TO, 3);
    return TO + 1;
  endfunction

  // Drive one cycle of inputs and queue the observation expected during that cycle
  task automatic step(input logic [2:0] st, input logic run, input logic imv, input logic rdy,
                      input logic vld, input logic [6:0] opc, input logic [5:0] sb);
    obs_t e;
    bus.MCU_Run_In        = run;
    bus.MCU_Imem_Valid_In = imv;
    bus.MCU_Lsu_Ready_In  = rdy;
    bus.MCU_Lsu_Valid_In  = vld;
    bus.MCU_Opcode_InBUS  = opc;
    e.st  = st;
    e.sb  = sb;
    e.cnt = model_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb[1]) model_cnt = model_cnt + RW'(1);
  endtask

  // Reset lands mid-cycle, so the following negedge sample checks its asynchronous effect
  task automatic do_reset(input int unsigned idle_n);
    rst_n = 1'b0;
    model_cnt = '0;
    step(S_IDLE, 1'b1, 1'b1, rb(), rb(), ro(), SB_NONE);
    rst_n = 1'b1;
    repeat (idle_n) step(S_IDLE, 1'b0, rb(), rb(), rb(), ro(), SB_NONE);
    step(S_IDLE, 1'b1, rb(), rb(), rb(), ro(), SB_NONE);
  endtask

  task automatic trap_then_reset();
    repeat ($urandom_range(6, 3)) step(S_TRAP, rb(), rb(), rb(), rb(), ro(), SB_TRP);
    do_reset($urandom_range(2, 0));
  endtask

  // n cycles with the awaited handshake low; the cycle seen with TO already counted traps
  task automatic wait_low(input logic [2:0] st, input int unsigned n, input logic [6:0] opc,
                          output bit trapped);
    logic imv, rdy, vld;
    trapped = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      imv = rb(); rdy = rb(); vld = rb();
      if (st == S_FETCH)       imv = 1'b0;
      else if (st == S_WREADY) rdy = 1'b0;
      else                     vld = 1'b0;
      step(st, rb(), imv, rdy, vld, (st == S_FETCH) ? ro() : opc,
           (st == S_FETCH) ? SB_REQ : SB_NONE);
      if (i == TO) begin
        trapped = 1'b1;
        return;
      end
    end
  endtask

  task automatic instr(input logic [6:0] opc, input int unsigned fd, input int unsigned rd,
                       input int unsigned vd);
    bit tr;
    bit is_mem;
    is_mem = (opc == OP_LW) || (opc == OP_SW);
    wait_low(S_FETCH, fd, opc, tr);
    if (tr) begin trap_then_reset(); return; end
    step(S_FETCH, rb(), 1'b1, rb(), rb(), opc, SB_REQ | SB_IRL);
    step(S_DECODE, rb(), rb(), rb(), rb(), opc, SB_NONE);
    if (!is_legal(opc)) begin trap_then_reset(); return; end
    if (!is_mem) begin
      step(S_EXEC, rb(), rb(), rb(), rb(), opc, SB_PCW | SB_RET);
      return;
    end
    step(S_EXEC, rb(), rb(), rb(), rb(), opc, SB_NONE);
    wait_low(S_WREADY, rd, opc, tr);
    if (tr) begin trap_then_reset(); return; end
    if (opc == OP_SW) begin
      step(S_WREADY, rb(), rb(), 1'b1, rb(), opc, SB_PCW | SB_RET);
      return;
    end
    step(S_WREADY, rb(), rb(), 1'b1, rb(), opc, SB_NONE);
    wait_low(S_WVALID, vd, opc, tr);
    if (tr) begin trap_then_reset(); return; end
    step(S_WVALID, rb(), rb(), rb(), 1'b1, opc, SB_LWB | SB_PCW | SB_RET);
  endtask

  // Park a load in WAIT_VALID with valid about to rise, then reset underneath it
  task automatic load_then_reset();
    step(S_FETCH, 1'b0, 1'b1, 1'b0, 1'b0, OP_LW, SB_REQ | SB_IRL);
    step(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, OP_LW, SB_NONE);
    step(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, OP_LW, SB_NONE);
    step(S_WREADY, 1'b0, 1'b0, 1'b1, 1'b0, OP_LW, SB_NONE);
    step(S_WVALID, 1'b0, 1'b0, 1'b0, 1'b0, OP_LW, SB_NONE);
    step(S_WVALID, 1'b0, 1'b0, 1'b0, 1'b0, OP_LW, SB_NONE);
    do_reset(1);
  endtask

  initial begin
    logic [6:0] opc;
    rst_n = 1'b0;
    bus.MCU_Run_In        = 1'b0;
    bus.MCU_Imem_Valid_In = 1'b0;
    bus.MCU_Lsu_Ready_In  = 1'b0;
    bus.MCU_Lsu_Valid_In  = 1'b0;
    bus.MCU_Opcode_InBUS  = OP_ADDI;
    model_cnt = '0;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    do_reset(2);
    repeat (3) instr(OP_ADDI, 0, 0, 0);
    instr(OP_LW, 0, 2, 3);
    instr(OP_SW, 0, 0, 0);
    instr(OP_SW, 1, 1, 0);
    instr(OP_LW, 2, 0, 0);
    instr(7'b1111111, 0, 0, 0);
    instr(OP_ADDI, TO + 1, 0, 0);
    instr(OP_ADDI, TO, 0, 0);
    instr(OP_SW, 0, TO, 0);
    instr(OP_SW, 0, TO + 1, 0);
    instr(OP_LW, 0, TO, TO);
    instr(OP_LW, 0, 0, TO + 1);
    load_then_reset();
    instr(OP_ADDI, 0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(9, 0) < 8) opc = LEGAL[$urandom_range(8, 0)];
      else                          opc = ro();
      instr(opc, pick_delay(), pick_delay(), pick_delay());
    end

    mon_en = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
